// File: rtl/sd_pkg.sv
// Shared definitions for the SD card access arbiter: the state encoding,
// the engine reset length and the default tuning constants.
package sd_pkg;

    typedef enum logic [2:0] {
        RST_ENG,
        INIT,
        INIT_ACK,
        READY,
        RD,
        WR,
        ACK,
        FAIL
    } sd_state_t;

    localparam int          RST_ENG_LEN    = 4;
    localparam logic [23:0] TMO_CYCLES_DEF = 24'd12_000_000;
    localparam int          ACK_HOLD_DEF   = 16;
    localparam int          INIT_RETRY_DEF = 3;
    localparam int          CNT_W          = 16;

    // States in which the engine may hang and the watchdog has to run
    function automatic logic is_timed(input sd_state_t s);
        return (s == INIT) || (s == RD) || (s == WR);
    endfunction

endpackage

// File: rtl/sd_wdog.sv
// Loadable down-counter used as the SD engine watchdog. Load arms it with
// the cycle budget, clear disarms it, expired is raised while it is armed,
// enabled and has run down to zero.
module sd_wdog #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;
    logic         armed;

    // Count down while enabled; clear and load take priority over counting
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_val;
            armed <= 1'b1;
        end else if (en && armed && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = armed && en && (count == '0);

endmodule

// File: rtl/sd_access_arb.sv
// Arbiter between a read and a write requester sharing one SD engine.
// Sequences engine reset and init, grants transfers round-robin and holds
// the fifo_busy acknowledge long enough for the slow sd_ck domain.
// Optional watchdog / retry / permanent failure: define SD_ACCESS_TIMEOUT_EN.
module sd_access_arb
    import sd_pkg::*;
#(
    parameter logic [23:0] TMO_CYCLES = TMO_CYCLES_DEF,
    parameter int          ACK_HOLD   = ACK_HOLD_DEF,
    parameter int          INIT_RETRY = INIT_RETRY_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_req,
    input  logic wr_req,
    input  logic init_ok,
    input  logic rd_ok,
    input  logic wr_ok,
    output logic sd_init,
    output logic sd_ren,
    output logic sd_wen,
    output logic fifo_busy,
    output logic eng_rst,
    output logic rd_done,
    output logic wr_done,
    output logic xfer_err,
    output logic init_fail,
    output logic ready
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_ENG_LEN - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_HOLD - 1);

    sd_state_t        state;
    sd_state_t        next_state;
    logic [CNT_W-1:0] cnt;
    logic             last_wr;
    logic             rd_seen;
    logic             wr_seen;
    logic             ack_ok;
    logic             fail_rd;
    logic             fail_wr;
    logic             tmo_hit;
    logic             retry_left;

    // The granted engine status; last_wr doubles as the current grant
    assign ack_ok  = last_wr ? wr_ok : rd_ok;
    assign fail_rd = rd_req && !rd_seen;
    assign fail_wr = wr_req && !wr_seen && !fail_rd;

`ifdef SD_ACCESS_TIMEOUT_EN
    logic [7:0] retry_cnt;
    logic       wd_load;
    logic       wd_clear;

    assign wd_load    = (next_state != state) && is_timed(next_state);
    assign wd_clear   = (next_state != state) && !is_timed(next_state);
    assign retry_left = (int'(retry_cnt) + 1) <= INIT_RETRY;

    sd_wdog #(
        .W (24)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear),
        .load     (wd_load),
        .load_val (TMO_CYCLES - 24'd1),
        .en       (is_timed(state)),
        .expired  (tmo_hit)
    );

    // Init retry bookkeeping: cleared by a good init or a transfer timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (state == INIT && init_ok) begin
            retry_cnt <= '0;
        end else if (state == INIT && tmo_hit) begin
            retry_cnt <= retry_cnt + 1'b1;
        end else if ((state == RD || state == WR) && next_state == RST_ENG) begin
            retry_cnt <= '0;
        end
    end

    assign init_fail = (state == FAIL);
`else
    assign tmo_hit    = 1'b0;
    assign retry_left = 1'b1;
    assign init_fail  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_ENG;
        end else begin
            state <= next_state;
        end
    end

    // Per-state cycle counter, restarted on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Round-robin history; starts as write so read wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr <= 1'b1;
        end else if (state == READY && next_state == RD) begin
            last_wr <= 1'b0;
        end else if (state == READY && next_state == WR) begin
            last_wr <= 1'b1;
        end
    end

    // In FAIL each request is refused once, until the requester drops it
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_seen <= 1'b0;
            wr_seen <= 1'b0;
        end else begin
            rd_seen <= (state == FAIL) && rd_req && (rd_seen || fail_rd);
            wr_seen <= (state == FAIL) && wr_req && (wr_seen || fail_wr);
        end
    end

    // Next-state and completion pulses
    always_comb begin
        next_state = state;
        rd_done    = 1'b0;
        wr_done    = 1'b0;
        xfer_err   = 1'b0;
        case (state)
            RST_ENG: begin
                if (cnt == RST_LAST) next_state = INIT;
            end
            INIT: begin
                if (init_ok) begin
                    next_state = INIT_ACK;
                end else if (tmo_hit) begin
                    next_state = retry_left ? RST_ENG : FAIL;
                end
            end
            INIT_ACK: begin
                if (cnt == ACK_LAST) next_state = READY;
            end
            READY: begin
                if (rd_req && (!wr_req || last_wr)) begin
                    next_state = RD;
                end else if (wr_req) begin
                    next_state = WR;
                end
            end
            RD: begin
                if (rd_ok) begin
                    next_state = ACK;
                end else if (tmo_hit) begin
                    next_state = RST_ENG;
                    rd_done    = 1'b1;
                    xfer_err   = 1'b1;
                end
            end
            WR: begin
                if (wr_ok) begin
                    next_state = ACK;
                end else if (tmo_hit) begin
                    next_state = RST_ENG;
                    wr_done    = 1'b1;
                    xfer_err   = 1'b1;
                end
            end
            ACK: begin
                if (cnt >= ACK_LAST && !ack_ok) begin
                    next_state = READY;
                    rd_done    = !last_wr;
                    wr_done    = last_wr;
                end
            end
            FAIL: begin
                rd_done  = fail_rd;
                wr_done  = fail_wr;
                xfer_err = fail_rd || fail_wr;
            end
            default: next_state = RST_ENG;
        endcase
    end

    assign eng_rst   = (state == RST_ENG);
    assign sd_init   = (state == INIT);
    assign sd_ren    = (state == RD);
    assign sd_wen    = (state == WR);
    assign fifo_busy = (state == INIT_ACK) || (state == ACK);
    assign ready     = (state == READY);

endmodule

// File: tb/tb_sd_access_arb.sv
// Directed bench for sd_access_arb. The timeout scenarios are compiled in
// only when SD_ACCESS_TIMEOUT_EN is defined for the whole build.
module tb_sd_access_arb;

    logic clk = 1'b0;
    logic rst;
    logic rd_req, wr_req, init_ok, rd_ok, wr_ok;
    logic sd_init, sd_ren, sd_wen, fifo_busy, eng_rst;
    logic rd_done, wr_done, xfer_err, init_fail, ready;
    logic [9:0] outv;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    always #5 clk = ~clk;

    sd_access_arb #(
        .TMO_CYCLES (24'd1000),
        .ACK_HOLD   (16),
        .INIT_RETRY (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .init_ok   (init_ok),
        .rd_ok     (rd_ok),
        .wr_ok     (wr_ok),
        .sd_init   (sd_init),
        .sd_ren    (sd_ren),
        .sd_wen    (sd_wen),
        .fifo_busy (fifo_busy),
        .eng_rst   (eng_rst),
        .rd_done   (rd_done),
        .wr_done   (wr_done),
        .xfer_err  (xfer_err),
        .init_fail (init_fail),
        .ready     (ready)
    );

    assign outv = {eng_rst, sd_init, sd_ren, sd_wen, fifo_busy,
                   rd_done, wr_done, xfer_err, init_fail, ready};

    // Read and write strobes must never be high together
    always @(negedge clk) begin
        if (sd_ren && sd_wen) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic io,
                                 input logic ro, input logic wo);
        rd_req  = r;
        wr_req  = w;
        init_ok = io;
        rd_ok   = ro;
        wr_ok   = wo;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model for init: init_ok 200 cycles after sd_init, then 16-cycle ack
    task automatic bringUp(input string tag);
        int n;
        n = 0;
        while (!sd_init && n < 50) begin
            tick();
            n++;
        end
        checkOutput({tag, " sd_init"}, 32'(sd_init), 32'd1);
        repeat (200) tick();
        checkOutput({tag, " sd_init held"}, 32'(sd_init), 32'd1);
        init_ok = 1'b1;
        tick();
        checkOutput({tag, " init ack entry"}, 32'({sd_init, fifo_busy}), 32'b01);
        init_ok = 1'b0;
        n = 0;
        while (fifo_busy && n < 100) begin
            n++;
            tick();
        end
        checkOutput({tag, " init fifo_busy len"}, 32'(n), 32'd16);
        checkOutput({tag, " ready"}, 32'(ready), 32'd1);
    endtask

    // Serve a granted transfer: engine answers after ans cycles, holds ok for hold ACK cycles
    task automatic serveXfer(input bit is_wr, input int ans, input int hold,
                             input int exp_ack, input bit drop, input string tag);
        int i;
        int bad;
        logic [1:0] strb;
        strb = is_wr ? 2'b01 : 2'b10;
        bad  = 0;
        checkOutput({tag, " grant"}, 32'({sd_ren, sd_wen}), 32'(strb));
        for (int k = 1; k < ans; k++) begin
            tick();
            if ({sd_ren, sd_wen} !== strb) bad++;
        end
        if (is_wr) wr_ok = 1'b1;
        else       rd_ok = 1'b1;
        tick();
        checkOutput({tag, " ack entry"}, 32'({sd_ren, sd_wen, fifo_busy}), 32'b001);
        i = 0;
        while (i < 300) begin
            if (is_wr) wr_ok = (i < hold);
            else       rd_ok = (i < hold);
            #1;
            if (rd_done || wr_done) break;
            if ({sd_ren, sd_wen} !== 2'b00 || !fifo_busy) bad++;
            tick();
            i++;
        end
        checkOutput({tag, " strobe shape"}, 32'(bad), 32'd0);
        checkOutput({tag, " ack length"}, 32'(i), 32'(exp_ack));
        checkOutput({tag, " done"}, 32'({rd_done, wr_done, xfer_err}),
                    is_wr ? 32'b010 : 32'b100);
        if (drop) begin
            if (is_wr) wr_req = 1'b0;
            else       rd_req = 1'b0;
        end
        rd_ok = 1'b0;
        wr_ok = 1'b0;
        tick();
        checkOutput({tag, " done single"}, 32'({rd_done, wr_done, ready}), 32'b001);
    endtask

    initial begin
        int n;
        int nres;
        logic prev;

        // Reset and power-up sequence
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset outputs", 32'(outv), 32'b10_0000_0000);
        rst = 1'b0;
        n = 0;
        while (eng_rst && n < 20) begin
            n++;
            tick();
        end
        checkOutput("eng_rst length", 32'(n), 32'd4);
        bringUp("power-up");

        // Simultaneous requests: read first, then write
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        serveXfer(1'b0, 100, 0, 15, 1'b1, "tie rd");
        tick();
        serveXfer(1'b1, 100, 20, 20, 1'b1, "tie wr");

        // Write held, read pulsed between grants: grants alternate
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        serveXfer(1'b0, 5, 0, 15, 1'b1, "rr rd1");
        rd_req = 1'b1;
        tick();
        serveXfer(1'b1, 5, 0, 15, 1'b0, "rr wr1");
        tick();
        serveXfer(1'b0, 5, 0, 15, 1'b1, "rr rd2");
        tick();
        serveXfer(1'b1, 5, 3, 15, 1'b1, "rr wr2");

        // Request dropped after grant still completes with a done pulse
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        serveXfer(1'b0, 10, 0, 15, 1'b1, "dropped rd");
        tick();
        checkOutput("idle after drop", 32'(outv), 32'b00_0000_0001);

        // Stray engine status in READY is ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        checkOutput("stray ok ignored", 32'(outv), 32'b00_0000_0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a read aborts it without a done pulse
        rd_req = 1'b1;
        tick();
        repeat (10) tick();
        checkOutput("mid-read strobe", 32'({sd_ren, sd_wen}), 32'b10);
        rst = 1'b1;
        tick();
        checkOutput("abort outputs", 32'(outv), 32'b10_0000_0000);
        tick();
        checkOutput("abort held", 32'(outv), 32'b10_0000_0000);
        rd_req = 1'b0;

`ifdef SD_ACCESS_TIMEOUT_EN
        // Engine never answers init: four engine resets, then FAIL
        rst  = 1'b0;
        nres = 1;
        prev = 1'b1;
        n    = 0;
        while (!init_fail && n < 20000) begin
            tick();
            n++;
            if (eng_rst && !prev) nres++;
            prev = eng_rst;
        end
        checkOutput("init_fail reached", 32'(init_fail), 32'd1);
        checkOutput("engine reset count", 32'(nres), 32'd4);
        checkOutput("fail outputs", 32'(outv), 32'b00_0000_0010);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("fail rd refused", 32'({rd_done, wr_done, xfer_err}), 32'b101);
        tick();
        checkOutput("fail wr refused", 32'({rd_done, wr_done, xfer_err}), 32'b011);
        tick();
        checkOutput("fail once each", 32'({rd_done, wr_done, xfer_err}), 32'b000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Write never acknowledged: error done after 1000 cycles, then re-init
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bringUp("tmo bring-up");
        wr_req = 1'b1;
        tick();
        checkOutput("tmo wr grant", 32'({sd_ren, sd_wen}), 32'b01);
        n = 0;
        while (n < 2000) begin
            if (wr_done) break;
            tick();
            n++;
        end
        checkOutput("tmo wr cycles", 32'(n), 32'd999);
        checkOutput("tmo wr err done", 32'({rd_done, wr_done, xfer_err}), 32'b011);
        wr_req = 1'b0;
        tick();
        checkOutput("tmo engine reset", 32'(outv), 32'b10_0000_0000);
        bringUp("tmo re-init");
`endif

        checkOutput("strobe overlap", 32'(overlap), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_access_arb.md
SD_ACCESS_ARB -- requirements
Module: sd_access_arb

Interface
REQ-001 Parameter TMO_CYCLES, default 24'd12_000_000, watchdog limit in clk cycles.
REQ-002 Parameter ACK_HOLD, default 16, minimum fifo_busy assertion in clk cycles; must exceed one sd_ck period of 12 clk.
REQ-003 Parameter INIT_RETRY, default 3, engine re-init attempts before permanent failure.
REQ-004 clk  input  1  single system clock, all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rd_req / wr_req  input  1 each  requester level requests, held until matching done pulse.
REQ-007 init_ok / rd_ok / wr_ok  input  1 each  status from the SD engine.
REQ-008 sd_init / sd_ren / sd_wen  output  1 each  engine start strobes, held levels.
REQ-009 fifo_busy  output  1  engine completion acknowledge.
REQ-010 eng_rst  output  1  active-high engine reset; top level inverts it onto the engine's rst_n.
REQ-011 rd_done / wr_done  output  1 each  one-cycle completion pulses to requesters.
REQ-012 xfer_err  output  1  qualifies a done pulse as failed, valid only in the cycle of the pulse.
REQ-013 init_fail  output  1  sticky; card unusable.
REQ-014 ready  output  1  high only in READY state.

Function
REQ-015 States: RST_ENG, INIT, INIT_ACK, READY, RD, WR, ACK, FAIL.
REQ-016 RST_ENG: eng_rst=1 for 4 cycles, then INIT.
REQ-017 INIT: sd_init=1 until init_ok=1, then INIT_ACK with sd_init=0.
REQ-018 INIT_ACK: fifo_busy=1 for exactly ACK_HOLD cycles, then READY.
REQ-019 READY: grant by round-robin; if only one req is high, grant it; if both are high, grant the one not granted last; after reset, read has priority. A grant takes effect the cycle after the req is sampled.
REQ-020 RD: sd_ren=1 until rd_ok=1. WR: sd_wen=1 until wr_ok=1. Then ACK, with the strobe deasserted in the same cycle as the ACK entry.
REQ-021 ACK: fifo_busy=1 for at least ACK_HOLD cycles and until the granted rd_ok/wr_ok reads 0. On exit, pulse the granted done for one cycle with xfer_err=0, then go to READY.
REQ-022 A req dropped before done is ignored once granted: the transfer completes and the done pulse is still issued.
REQ-023 sd_ren and sd_wen are never high together, and never high outside RD or WR.
REQ-024 rd_ok or wr_ok arriving outside RD/WR/ACK is ignored.
REQ-025 FAIL: all strobes 0, init_fail=1, ready=0. Any pending req receives a done pulse with xfer_err=1 on the first cycle it is high, one requester per cycle, read first. FAIL is left only through rst.

Reset
REQ-026 On rst=1 at a clk edge: state=RST_ENG, eng_rst=1, all other outputs 0, retry count 0, watchdog 0, last-grant=write (so read wins first tie).
REQ-027 rst during RD/WR aborts the transfer with no done pulse; the requester must re-request.

Configuration
REQ-028 Macro SD_ACCESS_TIMEOUT_EN.
- Defined: a watchdog counts cycles in INIT, RD and WR, clears on state entry, and expires at TMO_CYCLES.
- Expiry in INIT: retry count +1. If retries are left (count <= INIT_RETRY), go to RST_ENG; otherwise go to FAIL.
- Expiry in RD/WR: pulse the granted done with xfer_err=1, clear the retry count, go to RST_ENG.
- Retry count clears on a successful init_ok.
REQ-029 Not defined: no watchdog logic, INIT/RD/WR wait indefinitely, init_fail is tied 0, and xfer_err is 1 only in FAIL (unreachable).

Structure
REQ-030 Shared package sd_pkg holds the state enumeration, the RST_ENG length (4), and the default TMO_CYCLES/ACK_HOLD/INIT_RETRY constants.
REQ-031 One sub-module, sd_wdog: a loadable down-counter with clear and expired output, instantiated only under SD_ACCESS_TIMEOUT_EN.

Verification
REQ-032 Release rst; engine model raises init_ok 200 cycles after sd_init -> eng_rst high 4 cycles, sd_init high, fifo_busy high 16 cycles, ready=1.
REQ-033 rd_req and wr_req rise in the same cycle in READY, engine answers each in 100 cycles -> read served first, then write; each done pulses once with xfer_err=0; sd_ren and sd_wen never overlap.
REQ-034 wr_req held continuously with rd_req pulsed between grants -> grants alternate read and write.
REQ-035 Timeout build, TMO_CYCLES=1000, engine never raises init_ok -> 4 engine resets, then FAIL with init_fail=1; rd_req then yields rd_done with xfer_err=1.
REQ-036 Timeout build, wr_ok withheld -> wr_done with xfer_err=1 at 1000 cycles, then RST_ENG and re-init, then ready=1.
REQ-037 rst asserted mid-RD -> no rd_done, state RST_ENG, all strobes 0 the next cycle.
